// File: rtl/mul_issue_ctrl_pkg.sv
// Shared definitions for the EX-stage multiplier issue controller.
package mul_issue_ctrl_pkg;

  localparam int unsigned MulDataW   = 32;
  localparam int unsigned MulTimeout = 64;

  typedef logic [1:0] mul_state_t;

  localparam mul_state_t StIdle  = 2'd0;
  localparam mul_state_t StBusy  = 2'd1;
  localparam mul_state_t StDone  = 2'd2;
  localparam mul_state_t StAbort = 2'd3;

endpackage

// File: rtl/mul_issue_ctrl.sv
// EX-stage initiator for the multicycle multiplier: issues MULT/MULTU, stalls while it runs,
// captures HI/LO, and annuls the operation on a pipeline flush.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = MulDataW,
  parameter int unsigned TIMEOUT = MulTimeout
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ex_valid_i,
  input  logic                ex_mul_i,
  input  logic                ex_signed_i,
  input  logic [DATA_W-1:0]   ex_rs_i,
  input  logic [DATA_W-1:0]   ex_rt_i,
  input  logic                ex_adv_i,
  input  logic                flush_i,
  output logic [DATA_W-1:0]   mul_opdata1_o,
  output logic [DATA_W-1:0]   mul_opdata2_o,
  output logic                mul_signed_o,
  output logic                mul_start_o,
  output logic                mul_annul_o,
  input  logic [2*DATA_W-1:0] mul_result_i,
  input  logic                mul_ready_i,
  output logic                stall_o,
  output logic                res_valid_o,
  output logic [DATA_W-1:0]   res_hi_o,
  output logic [DATA_W-1:0]   res_lo_o,
  output logic                err_o
);

  localparam logic [7:0] TimeoutCnt = TIMEOUT[7:0];

  mul_state_t        state_q, state_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic              signed_q, signed_d;
  logic              start_q, start_d;
  logic              annul_q, annul_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_hi_q, res_hi_d;
  logic [DATA_W-1:0] res_lo_q, res_lo_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req;

  assign req = ex_valid_i & ex_mul_i & ~flush_i;

  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    signed_d    = signed_q;
    start_d     = start_q;
    annul_d     = annul_q;
    res_valid_d = res_valid_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    stall_o     = 1'b0;

    unique case (state_q)
      StIdle: begin
        stall_o = req;
        if (req) begin
          op1_d    = ex_rs_i;
          op2_d    = ex_rt_i;
          signed_d = ex_signed_i;
          start_d  = 1'b1;
          cnt_d    = 8'd0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        stall_o = 1'b1;
        if (flush_i) begin
          start_d = 1'b0;
          annul_d = 1'b1;
          state_d = StAbort;
        end else if (mul_ready_i) begin
          res_hi_d    = mul_result_i[2*DATA_W-1:DATA_W];
          res_lo_d    = mul_result_i[DATA_W-1:0];
          res_valid_d = 1'b1;
          start_d     = 1'b0;
          state_d     = StDone;
        end else begin
          // Counter holds completed BUSY cycles and saturates at the limit.
          if (cnt_q != TimeoutCnt) begin
            cnt_d = cnt_q + 8'd1;
          end
          if (cnt_d == TimeoutCnt) begin
            err_d = 1'b1;
          end
        end
      end
      StDone: begin
        // Hold the result until EX advances so a stalled MUL is never reissued.
        if (ex_adv_i | flush_i) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StAbort: begin
        stall_o = ex_valid_i & ex_mul_i;
        annul_d = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      op1_q       <= '0;
      op2_q       <= '0;
      signed_q    <= 1'b0;
      start_q     <= 1'b0;
      annul_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      signed_q    <= signed_d;
      start_q     <= start_d;
      annul_q     <= annul_d;
      res_valid_q <= res_valid_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mul_opdata1_o = op1_q;
  assign mul_opdata2_o = op2_q;
  assign mul_signed_o  = signed_q;
  assign mul_start_o   = start_q;
  assign mul_annul_o   = annul_q;
  assign res_valid_o   = res_valid_q;
  assign res_hi_o      = res_hi_q;
  assign res_lo_o      = res_lo_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: programmable-latency multiplier model, flag-based reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_mul_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid, ex_mul, ex_signed, ex_adv, flush;
  logic [31:0] ex_rs, ex_rt;
  logic [31:0] mul_op1, mul_op2, res_hi, res_lo;
  logic        mul_signed, mul_start, mul_annul, stall, res_valid, err;
  logic [63:0] mr_result;
  logic        mr_ready;

  int total = 0;
  int bad   = 0;
  int issues = 0;
  int lat   = 3;
  logic never = 1'b0;

  always #5 clk = ~clk;

  mul_issue_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .ex_valid_i   (ex_valid),
    .ex_mul_i     (ex_mul),
    .ex_signed_i  (ex_signed),
    .ex_rs_i      (ex_rs),
    .ex_rt_i      (ex_rt),
    .ex_adv_i     (ex_adv),
    .flush_i      (flush),
    .mul_opdata1_o(mul_op1),
    .mul_opdata2_o(mul_op2),
    .mul_signed_o (mul_signed),
    .mul_start_o  (mul_start),
    .mul_annul_o  (mul_annul),
    .mul_result_i (mr_result),
    .mul_ready_i  (mr_ready),
    .stall_o      (stall),
    .res_valid_o  (res_valid),
    .res_hi_o     (res_hi),
    .res_lo_o     (res_lo),
    .err_o        (err)
  );

  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Multiplier model: samples operands on the first start cycle, reads signed at completion.
  int          mr_cnt;
  logic        mr_run;
  logic [31:0] mr_a, mr_b;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mr_run <= 1'b0; mr_ready <= 1'b0; mr_cnt <= 0;
      mr_a <= '0; mr_b <= '0; mr_result <= '0;
    end else if (mul_annul || !mul_start) begin
      mr_run <= 1'b0; mr_ready <= 1'b0;
    end else if (!mr_run && !mr_ready) begin
      mr_run <= 1'b1; mr_cnt <= lat; mr_a <= mul_op1; mr_b <= mul_op2;
    end else if (mr_run && !never) begin
      if (mr_cnt <= 1) begin
        mr_run <= 1'b0; mr_ready <= 1'b1; mr_result <= mul64(mr_a, mr_b, mul_signed);
      end else begin
        mr_cnt <= mr_cnt - 1;
      end
    end
  end

  // Reference model in terms of "operation in flight / result held / annul pending".
  logic        m_active, m_hold, m_abort, m_err, m_sgn;
  logic [31:0] m_op1, m_op2, m_hi, m_lo;
  int          m_busy_n;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_active <= 1'b0; m_hold <= 1'b0; m_abort <= 1'b0; m_err <= 1'b0; m_sgn <= 1'b0;
      m_op1 <= '0; m_op2 <= '0; m_hi <= '0; m_lo <= '0; m_busy_n <= 0;
    end else if (m_abort) begin
      m_abort <= 1'b0;
    end else if (m_active) begin
      if (flush) begin
        m_active <= 1'b0; m_abort <= 1'b1;
      end else if (mr_ready) begin
        m_active <= 1'b0; m_hold <= 1'b1;
        {m_hi, m_lo} <= mul64(m_op1, m_op2, m_sgn);
      end else begin
        m_busy_n <= m_busy_n + 1;
        if (m_busy_n + 1 >= 64) m_err <= 1'b1;
      end
    end else if (m_hold) begin
      if (ex_adv || flush) m_hold <= 1'b0;
    end else if (ex_valid && ex_mul && !flush) begin
      m_active <= 1'b1; m_busy_n <= 0;
      m_op1 <= ex_rs; m_op2 <= ex_rt; m_sgn <= ex_signed;
    end
  end

  logic last_start = 1'b0;
  always @(negedge clk) begin
    logic exp_stall, rise;
    if (m_active) exp_stall = 1'b1;
    else if (m_hold) exp_stall = 1'b0;
    else if (m_abort) exp_stall = ex_valid & ex_mul;
    else exp_stall = ex_valid & ex_mul & ~flush;
    chk("start", mul_start, m_active);
    chk("annul", mul_annul, m_abort);
    chk("stall", stall, exp_stall);
    chk("res_valid", res_valid, m_hold);
    chk("res_hi", res_hi, m_hi);
    chk("res_lo", res_lo, m_lo);
    chk("op1", mul_op1, m_op1);
    chk("op2", mul_op2, m_op2);
    chk("signed", mul_signed, m_sgn);
    chk("err", err, m_err);
    rise = mul_start & ~last_start;
    if (rise) begin
      issues++;
      chk("start_vs_ready", mr_ready, 1'b0);
    end
    last_start = mul_start;
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    ex_valid = 1'b1; ex_mul = 1'b1; ex_rs = a; ex_rt = b; ex_signed = s;
  endtask

  task automatic wait_res();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    chk("res_valid_wait", res_valid, 1'b1);
  endtask

  task automatic retire();
    @(posedge clk); #1 ex_adv = 1'b1;
    @(posedge clk); #1 ex_adv = 1'b0; ex_valid = 1'b0; ex_mul = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        s;
    int          l;
    logic [63:0] p;
  } vec_t;
  vec_t b2b[3];
  int   n0;

  initial begin
    b2b[0] = '{a: 32'd100, b: 32'd200, s: 1'b0, l: 1, p: 64'd20000};
    b2b[1] = '{a: 32'h8000_0000, b: 32'd2, s: 1'b1, l: 2, p: 64'hFFFF_FFFF_0000_0000};
    b2b[2] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, s: 1'b0, l: 4, p: 64'hFFFF_FFFE_0000_0001};

    resetn = 1'b0; ex_valid = 1'b0; ex_mul = 1'b0; ex_signed = 1'b0; ex_adv = 1'b0;
    flush = 1'b0; ex_rs = '0; ex_rt = '0;
    repeat (2) @(negedge clk);
    chk("rst_start", mul_start, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_res_lo", res_lo, 32'd0);
    @(posedge clk); #1 resetn = 1'b1;

    // 1: signed 7 * -3
    lat = 3;
    issue(32'h0000_0007, 32'hFFFF_FFFD, 1'b1);
    @(negedge clk);
    chk("t1_stall_req", stall, 1'b1);
    chk("t1_start_not_yet", mul_start, 1'b0);
    @(negedge clk);
    chk("t1_start", mul_start, 1'b1);
    wait_res();
    chk("t1_hi", res_hi, 32'hFFFF_FFFF);
    chk("t1_lo", res_lo, 32'hFFFF_FFEB);
    retire();

    // 2: unsigned, same operands
    lat = 5;
    issue(32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
    wait_res();
    chk("t2_hi", res_hi, 32'h0000_0006);
    chk("t2_lo", res_lo, 32'hFFFF_FFEB);
    retire();

    // 3: flush three cycles into BUSY, then 2*3
    lat = 10;
    issue(32'd5, 32'd6, 1'b1);
    @(negedge clk); @(negedge clk);
    @(posedge clk); @(posedge clk); #1 flush = 1'b1; ex_valid = 1'b0; ex_mul = 1'b0;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("t3_annul", mul_annul, 1'b1);
    chk("t3_no_res", res_valid, 1'b0);
    @(negedge clk);
    chk("t3_annul_one_cycle", mul_annul, 1'b0);
    lat = 2;
    @(posedge clk); #1 issue(32'd2, 32'd3, 1'b0);
    wait_res();
    chk("t3_lo", res_lo, 32'd6);
    chk("t3_hi", res_hi, 32'd0);
    retire();

    // 4: EX held in DONE for 5 cycles
    lat = 3;
    n0 = issues;
    issue(32'd9, 32'd11, 1'b0);
    wait_res();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", res_valid, 1'b1);
      chk("t4_hold_start", mul_start, 1'b0);
      chk("t4_hold_lo", res_lo, 32'd99);
    end
    retire();
    repeat (3) @(negedge clk);
    chk("t4_one_issue", 64'(issues - n0), 64'd1);

    // 5: back-to-back MULs
    for (int i = 0; i < 3; i++) begin
      lat = b2b[i].l;
      issue(b2b[i].a, b2b[i].b, b2b[i].s);
      wait_res();
      chk("t5_product", {res_hi, res_lo}, b2b[i].p);
      @(posedge clk); #1 ex_adv = 1'b1;
      @(posedge clk); #1 ex_adv = 1'b0;
    end
    ex_valid = 1'b0; ex_mul = 1'b0;
    repeat (2) @(negedge clk);

    // 6: multiplier never answers, then reset mid-BUSY
    never = 1'b1;
    @(posedge clk); #1 issue(32'd5, 32'd5, 1'b1);
    repeat (64) @(posedge clk);
    @(negedge clk);
    chk("t6_err_not_yet", err, 1'b0);
    @(negedge clk);
    chk("t6_err", err, 1'b1);
    @(negedge clk); #2 resetn = 1'b0; ex_valid = 1'b0; ex_mul = 1'b0;
    #1;
    chk("t6_rst_start", mul_start, 1'b0);
    chk("t6_rst_err", err, 1'b0);
    chk("t6_rst_stall", stall, 1'b0);
    chk("t6_rst_op1", mul_op1, 32'd0);
    chk("t6_rst_signed", mul_signed, 1'b0);
    never = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    chk("t6_err_after_rst", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
